// File: rtl/uart_core_sched.sv
// Avalon-MM master for uart_core: shares the transmitter between two byte requesters
// (round-robin, STATUS-polled) and drains received bytes on IRQ into a valid/ready output.
module uart_core_sched #(
   parameter int         POLL_GAP    = 4,
   parameter logic [3:0] ADDR_TXDATA = 4'h0,
   parameter logic [3:0] ADDR_STATUS = 4'h1,
   parameter logic [3:0] ADDR_RXDATA = 4'h2
) (
   input  logic       clk_i,
   input  logic       arst_n_i,
   input  logic [7:0] req0_data_i,
   input  logic       req0_valid_i,
   output logic       req0_ready_o,
   input  logic [7:0] req1_data_i,
   input  logic       req1_valid_i,
   output logic       req1_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic [3:0] avm_address_o,
   output logic       avm_byteenable_o,
   output logic       avm_read_o,
   output logic       avm_write_o,
   output logic [7:0] avm_writedata_o,
   input  logic [7:0] avm_readdata_i,
   input  logic       uart_irq_i,
   output logic       busy_o
);
   // state     | meaning
   // IDLE      | pick RX service (priority) or a TX poll for the held/new grant
   // POLL_RD   | STATUS read strobe
   // POLL_WAIT | STATUS readdata valid; decide write, back-off or release
   // GAP       | back-off after a busy poll, grant kept
   // TX_WR     | TXDATA write strobe, granted requester's ready pulses
   // RX_RD     | RXDATA read strobe
   // RX_WAIT   | capture received byte into the output register
   // SETTLE    | give uart_core a cycle to drop IRQ before it is looked at again

   localparam int GAP_W = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE, S_POLL_RD, S_POLL_WAIT, S_GAP, S_TX_WR, S_RX_RD, S_RX_WAIT, S_SETTLE
   } state_t;

   state_t             state, state_nx;
   logic               grant_held, grant_held_nx;
   logic               grant_id, grant_id_nx;
   logic               rr_ptr, rr_ptr_nx;
   logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
   logic               granted_valid;
   logic [7:0]         granted_data;

   assign granted_valid = grant_id ? req1_valid_i : req0_valid_i;
   assign granted_data  = grant_id ? req1_data_i  : req0_data_i;
   assign busy_o        = (state != S_IDLE);

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state      <= S_IDLE;
         grant_held <= 1'b0;
         grant_id   <= 1'b0;
         rr_ptr     <= 1'b0;
         gap_cnt    <= '0;
      end else begin
         state      <= state_nx;
         grant_held <= grant_held_nx;
         grant_id   <= grant_id_nx;
         rr_ptr     <= rr_ptr_nx;
         gap_cnt    <= gap_cnt_nx;
      end
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         rx_data_o  <= 8'h00;
         rx_valid_o <= 1'b0;
      end else if (state == S_RX_WAIT) begin
         rx_data_o  <= avm_readdata_i;
         rx_valid_o <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
         rx_valid_o <= 1'b0;
      end
   end

   always_comb begin
      state_nx         = state;
      grant_held_nx    = grant_held;
      grant_id_nx      = grant_id;
      rr_ptr_nx        = rr_ptr;
      gap_cnt_nx       = gap_cnt;
      avm_address_o    = ADDR_STATUS;
      avm_read_o       = 1'b0;
      avm_write_o      = 1'b0;
      avm_byteenable_o = 1'b0;
      avm_writedata_o  = 8'h00;
      req0_ready_o     = 1'b0;
      req1_ready_o     = 1'b0;
      case (state)
         S_IDLE: begin
            if (uart_irq_i && !rx_valid_o) begin
               state_nx = S_RX_RD;
            end else if (grant_held || req0_valid_i || req1_valid_i) begin
               state_nx = S_POLL_RD;
               if (!grant_held) begin
                  grant_held_nx = 1'b1;
                  grant_id_nx   = (req0_valid_i && req1_valid_i) ? rr_ptr : req1_valid_i;
               end
            end
         end
         S_POLL_RD: begin
            avm_read_o    = 1'b1;
            avm_address_o = ADDR_STATUS;
            state_nx      = S_POLL_WAIT;
         end
         S_POLL_WAIT: begin
            if (!granted_valid) begin
               grant_held_nx = 1'b0;
               state_nx      = S_IDLE;
            end else if (avm_readdata_i[0]) begin
               state_nx = S_TX_WR;
            end else if (POLL_GAP == 0) begin
               state_nx = S_IDLE;
            end else begin
               gap_cnt_nx = GAP_LOAD;
               state_nx   = S_GAP;
            end
         end
         S_GAP: begin
            // grant stays latched so a slow transmitter cannot starve the holder
            if (gap_cnt == '0) state_nx = S_IDLE;
            else               gap_cnt_nx = gap_cnt - 1'b1;
         end
         S_TX_WR: begin
            avm_write_o      = 1'b1;
            avm_address_o    = ADDR_TXDATA;
            avm_byteenable_o = 1'b1;
            avm_writedata_o  = granted_data;
            req0_ready_o     = !grant_id;
            req1_ready_o     = grant_id;
            rr_ptr_nx        = !grant_id;
            grant_held_nx    = 1'b0;
            state_nx         = S_IDLE;
         end
         S_RX_RD: begin
            avm_read_o    = 1'b1;
            avm_address_o = ADDR_RXDATA;
            state_nx      = S_RX_WAIT;
         end
         S_RX_WAIT: state_nx = S_SETTLE;
         S_SETTLE:  state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_core_sched.sv
// Scoreboard bench for uart_core_sched: behavioural uart_core and requesters, directed
// scenarios followed by randomized traffic, monitor checks every bus cycle.
module tb_uart_core_sched;
   localparam int POLL_GAP = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [3:0] addr;
   logic       be, rd, wr, busy, irq;
   logic [7:0] wdata;
   logic [7:0] rdata = 8'h00;

   uart_core_sched #(.POLL_GAP(POLL_GAP)) dut (
      .clk_i(clk), .arst_n_i(rst_n),
      .req0_data_i(req0_data), .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
      .req1_data_i(req1_data), .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
      .avm_address_o(addr), .avm_byteenable_o(be), .avm_read_o(rd), .avm_write_o(wr),
      .avm_writedata_o(wdata), .avm_readdata_i(rdata), .uart_irq_i(irq), .busy_o(busy));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // uart_core model: stim owns inj_cnt/rx_byte/status_*/busy_len, model owns the rest
   int         inj_cnt = 0, clr_cnt = 0;
   logic [7:0] rx_byte = 8'h00;
   logic [7:0] status_arr [64];
   int         status_len = 0, status_idx = 0;
   int         busy_len = 0, tx_busy = 0;
   assign irq = (inj_cnt != clr_cnt);

   always @(posedge clk) begin
      if (tx_busy > 0) tx_busy <= tx_busy - 1;
      if (rst_n && rd) begin
         if (addr == 4'h1) begin
            if (status_idx < status_len) begin
               rdata      <= status_arr[status_idx % 64];
               status_idx <= status_idx + 1;
            end else begin
               rdata <= {6'b0, irq, (tx_busy == 0)};
            end
         end else if (addr == 4'h2) begin
            rdata <= rx_byte;
            if (irq) clr_cnt <= clr_cnt + 1;
         end else begin
            rdata <= 8'h00;
         end
      end
      if (rst_n && wr) tx_busy <= busy_len;
   end

   // requester byte streams and expected RX bytes (pushed by stimulus only)
   logic [7:0] tx0_q[$], tx1_q[$], exp_rx[$];
   int rd0 = 0, rd1 = 0;

   typedef struct {int cyc; bit w; logic [3:0] addr; logic [7:0] data; int who;} ev_t;
   ev_t ev_q[$];

   // monitor / scoreboard
   int mi0 = 0, mi1 = 0, mr = 0;
   int last_poll_cyc = -100;
   bit prev_status_rd = 0, last_ready = 0, last_poll_busy = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_status_rd = 0;
            last_ready     = 0;
            last_poll_busy = 0;
         end else begin
            if (prev_status_rd) begin
               last_ready     = rdata[0];
               last_poll_busy = !rdata[0];
            end
            prev_status_rd = 0;
            if (rd && wr) chk("rd_wr_overlap", 1, 0);
            if (rd) begin
               chk("rd_addr_legal", int'(addr == 4'h1 || addr == 4'h2), 1);
               ev_q.push_back('{cyc, 1'b0, addr, 8'h00, -1});
               if (addr == 4'h1) begin
                  if (last_poll_busy) chk("poll_gap", int'(cyc - last_poll_cyc >= POLL_GAP + 3), 1);
                  last_poll_cyc  = cyc;
                  prev_status_rd = 1;
               end else if (addr == 4'h2) begin
                  chk("rx_rd_irq", int'(irq), 1);
                  chk("rx_rd_while_full", int'(rx_valid), 0);
               end
            end
            if (wr) begin
               chk("wr_addr", int'(addr), 0);
               chk("wr_be", int'(be), 1);
               chk("wr_after_ready_poll", int'(cyc == last_poll_cyc + 2 && last_ready), 1);
               chk("ready_onehot", int'(req0_ready) + int'(req1_ready), 1);
               if (req0_ready) begin
                  chk("tx0_in_range", int'(mi0 < tx0_q.size()), 1);
                  if (mi0 < tx0_q.size()) chk("tx0_data", int'(wdata), int'(tx0_q[mi0]));
                  mi0++;
               end
               if (req1_ready) begin
                  chk("tx1_in_range", int'(mi1 < tx1_q.size()), 1);
                  if (mi1 < tx1_q.size()) chk("tx1_data", int'(wdata), int'(tx1_q[mi1]));
                  mi1++;
               end
               ev_q.push_back('{cyc, 1'b1, addr, wdata, req1_ready ? 1 : 0});
            end else if (be || req0_ready || req1_ready) begin
               chk("strobe_without_write", int'(be) + int'(req0_ready) + int'(req1_ready), 0);
            end
            if (rx_valid && rx_ready) begin
               chk("rx_in_range", int'(mr < exp_rx.size()), 1);
               if (mr < exp_rx.size()) chk("rx_data", int'(rx_data), int'(exp_rx[mr]));
               mr++;
            end
         end
      end
   end

   task automatic drive_reqs();
      req0_valid = (rd0 < tx0_q.size());
      req0_data  = req0_valid ? tx0_q[rd0] : 8'h00;
      req1_valid = (rd1 < tx1_q.size());
      req1_data  = req1_valid ? tx1_q[rd1] : 8'h00;
   endtask

   // one clock: sample consumption mid-cycle, advance streams just after the edge
   task automatic step();
      logic c0, c1;
      @(negedge clk);
      c0 = req0_ready;
      c1 = req1_ready;
      @(posedge clk);
      #1;
      if (c0) rd0++;
      if (c1) rd1++;
      drive_reqs();
   endtask

   task automatic run_until(input int n0, input int n1, input int lim, input string name);
      int i = 0;
      while ((rd0 < n0 || rd1 < n1) && i < lim) begin
         step();
         i++;
      end
      chk(name, int'(rd0 >= n0 && rd1 >= n1), 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_read", int'(rd), 0);
      chk("rst_write", int'(wr), 0);
      chk("rst_be", int'(be), 0);
      chk("rst_addr", int'(addr), 1);
      chk("rst_ready", int'(req0_ready) + int'(req1_ready), 0);
      chk("rst_rx_valid", int'(rx_valid), 0);
      chk("rst_busy", int'(busy), 0);
      repeat (3) step();
      rst_n = 1'b1;
   endtask

   task automatic inject_rx(input logic [7:0] b);
      rx_byte = b;
      exp_rx.push_back(b);
      inj_cnt++;
   endtask

   task automatic rand_step();
      if ($urandom_range(0, 7) == 0 && tx0_q.size() - rd0 < 4) tx0_q.push_back(8'($urandom));
      if ($urandom_range(0, 7) == 0 && tx1_q.size() - rd1 < 4) tx1_q.push_back(8'($urandom));
      if (!irq && $urandom_range(0, 15) == 0) inject_rx(8'($urandom));
      rx_ready = ($urandom_range(0, 2) != 0);
      busy_len = $urandom_range(0, 6);
      drive_reqs();
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, base, n, p, found;
      ev_t w[$];

      @(posedge clk);
      #1;
      do_reset();
      step();

      // 1: single req0 byte, transmitter ready
      k = cyc; base = ev_q.size();
      tx0_q.push_back(8'h48); drive_reqs();
      run_until(1, 0, 20, "t1_done");
      chk("t1_nev", ev_q.size() - base, 2);
      chk("t1_rd_cyc", ev_q[base].cyc - k, 1);
      chk("t1_rd_addr", int'(ev_q[base].addr), 1);
      chk("t1_wr_cyc", ev_q[base+1].cyc - k, 3);
      chk("t1_wr_data", int'(ev_q[base+1].data), 'h48);
      chk("t1_wr_who", ev_q[base+1].who, 0);

      // 2: req1 with three busy polls
      for (int i = 0; i < 4; i++) status_arr[(status_idx + i) % 64] = (i == 3) ? 8'h01 : 8'h00;
      status_len = status_idx + 4;
      k = cyc; base = ev_q.size();
      tx1_q.push_back(8'h4C); drive_reqs();
      run_until(0, 1, 80, "t2_done");
      chk("t2_nev", ev_q.size() - base, 5);
      for (int i = 0; i < 4; i++) begin
         chk("t2_poll_cyc", ev_q[base+i].cyc - k, 1 + 7 * i);
         chk("t2_poll_rd", int'(!ev_q[base+i].w && ev_q[base+i].addr == 4'h1), 1);
      end
      chk("t2_wr_cyc", ev_q[base+4].cyc - k, 24);
      chk("t2_wr_data", int'(ev_q[base+4].data), 'h4C);
      chk("t2_wr_who", ev_q[base+4].who, 1);

      // 3: both continuously valid after reset, alternation starting at req0
      do_reset();
      step();
      base = ev_q.size();
      for (int i = 0; i < 3; i++) begin
         tx0_q.push_back(8'hA0);
         tx1_q.push_back(8'hB0);
      end
      drive_reqs();
      run_until(tx0_q.size(), tx1_q.size(), 60, "t3_done");
      w.delete();
      for (int i = base; i < ev_q.size(); i++) if (ev_q[i].w) w.push_back(ev_q[i]);
      chk("t3_nwr", w.size(), 6);
      for (int i = 0; i < w.size(); i++) begin
         chk("t3_order", int'(w[i].data), (i % 2 == 0) ? 'hA0 : 'hB0);
         if (i > 0) chk("t3_spacing", w[i].cyc - w[i-1].cyc, 4);
      end

      // 4: IRQ and req0 in the same cycle, RX serviced first
      k = cyc; base = ev_q.size();
      inject_rx(8'h5A);
      tx0_q.push_back(8'h33); drive_reqs();
      run_until(tx0_q.size(), 0, 30, "t4_done");
      chk("t4_nev", ev_q.size() - base, 3);
      chk("t4_rx_rd", int'(ev_q[base].addr) * 256 + ev_q[base].cyc - k, 2 * 256 + 1);
      chk("t4_poll", int'(ev_q[base+1].addr) * 256 + ev_q[base+1].cyc - k, 1 * 256 + 5);
      chk("t4_wr", int'(ev_q[base+2].data) * 256 + ev_q[base+2].cyc - k, 'h33 * 256 + 7);
      chk("t4_rx_valid", int'(rx_valid), 1);
      chk("t4_rx_data", int'(rx_data), 'h5A);

      // 5: output held, IRQ pending, TX continues
      base = ev_q.size();
      inject_rx(8'hC3);
      tx1_q.push_back(8'h11);
      tx0_q.push_back(8'h22);
      drive_reqs();
      run_until(tx0_q.size(), tx1_q.size(), 40, "t5_done");
      n = 0;
      w.delete();
      for (int i = base; i < ev_q.size(); i++) begin
         if (!ev_q[i].w && ev_q[i].addr == 4'h2) n++;
         if (ev_q[i].w) w.push_back(ev_q[i]);
      end
      chk("t5_no_rx_rd", n, 0);
      chk("t5_nwr", w.size(), 2);
      if (w.size() == 2) chk("t5_order", int'(w[0].data) * 256 + int'(w[1].data), 'h1122);
      chk("t5_still_held", int'(rx_valid) * 256 + int'(rx_data), 256 + 'h5A);
      p = cyc; base = ev_q.size();
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      found = -1;
      for (int i = 0; i < 10 && found < 0; i++) begin
         step();
         for (int j = base; j < ev_q.size(); j++)
            if (found < 0 && !ev_q[j].w && ev_q[j].addr == 4'h2) found = ev_q[j].cyc;
      end
      chk("t5_rx_rd_cyc", found - p, 2);
      step();
      chk("t5_rx_next", int'(rx_valid) * 256 + int'(rx_data), 256 + 'hC3);
      rx_ready = 1'b1;
      repeat (3) step();
      rx_ready = 1'b0;

      // 6: reset during POLL_WAIT of a req0 byte while RR points at req1
      k = cyc;
      tx0_q.push_back(8'h77); drive_reqs();
      step();
      step();
      chk("t6_in_poll", int'(busy) * 256 + int'(ev_q[ev_q.size()-1].addr), 256 + 1);
      chk("t6_poll_cyc", ev_q[ev_q.size()-1].cyc - k, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_rd", int'(rd), 0);
      chk("t6_rst_wr", int'(wr), 0);
      chk("t6_rst_busy", int'(busy), 0);
      chk("t6_rst_ready0", int'(req0_ready), 0);
      tx1_q.push_back(8'h88); drive_reqs();
      repeat (3) step();
      chk("t6_not_consumed", rd0, tx0_q.size() - 1);
      rst_n = 1'b1;
      base = ev_q.size();
      run_until(tx0_q.size(), tx1_q.size(), 40, "t6_done");
      w.delete();
      for (int i = base; i < ev_q.size(); i++) if (ev_q[i].w) w.push_back(ev_q[i]);
      chk("t6_nwr", w.size(), 2);
      if (w.size() == 2) chk("t6_order", int'(w[0].data) * 256 + int'(w[1].data), 'h7788);

      // randomized traffic
      for (int i = 0; i < 1500; i++) rand_step();
      rx_ready = 1'b1;
      busy_len = 0;
      n = 0;
      while ((rd0 < tx0_q.size() || rd1 < tx1_q.size() || irq || rx_valid) && n < 2000) begin
         step();
         n++;
      end
      chk("drain_done", int'(rd0 == tx0_q.size() && rd1 == tx1_q.size() && !irq && !rx_valid), 1);
      chk("sb_tx0_all", mi0, tx0_q.size());
      chk("sb_tx1_all", mi1, tx1_q.size());
      chk("sb_rx_all", mr, exp_rx.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
